// File: rtl/cla_pkg.sv
// rtl/cla_pkg.sv - shared constants and 4-bit lookahead carry equations for cla_adder
// Used by cla_block4 and cla_adder.
package cla_pkg;

  localparam int CLA_GROUP         = 4;
  localparam int CLA_DEFAULT_WIDTH = 4;

  // c[0] is the group carry-in; c[1..3] are the internal bit carries.
  typedef struct packed {
    logic [CLA_GROUP-1:0] c;
    logic                 gg;
    logic                 gp;
  } cla_carry_t;

  // Two-level lookahead: every carry is a flat sum of products, with no ripple.
  function automatic cla_carry_t cla_lookahead(
    input logic [CLA_GROUP-1:0] g,
    input logic [CLA_GROUP-1:0] p,
    input logic                 cin
  );
    cla_carry_t r;
    r.c[0] = cin;
    r.c[1] = g[0] | (p[0] & cin);
    r.c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    r.c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
    r.gg   = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
    r.gp   = &p;
    return r;
  endfunction

endpackage

// File: rtl/cla_block4.sv
// rtl/cla_block4.sv - combinational 4-bit carry-lookahead group
// Produces the group sum plus group generate/propagate for the second-level chain.
module cla_block4
  import cla_pkg::*;
(
  input  logic [CLA_GROUP-1:0] a,
  input  logic [CLA_GROUP-1:0] b,
  input  logic                 cin,
  output logic [CLA_GROUP-1:0] sum,
  output logic                 grp_g,
  output logic                 grp_p
);

  logic [CLA_GROUP-1:0] g;
  logic [CLA_GROUP-1:0] p;
  cla_carry_t           la;

  assign g     = a & b;
  assign p     = a ^ b;
  assign la    = cla_lookahead(g, p, cin);
  assign sum   = p ^ la.c;
  assign grp_g = la.gg;
  assign grp_p = la.gp;

endmodule

// File: rtl/cla_adder.sv
// rtl/cla_adder.sv - registered carry-lookahead adder built from 4-bit groups
// Optional input register stage under CLA_INPUT_REG_EN (latency 2 instead of 1).
module cla_adder
  import cla_pkg::*;
#(
  parameter int WIDTH = CLA_DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] A_in,
  input  logic [WIDTH-1:0] B_in,
  input  logic             Cin,
  output logic [WIDTH-1:0] S,
  output logic             Cout
);

  localparam int NG = WIDTH / CLA_GROUP;

  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             op_cin;

`ifdef CLA_INPUT_REG_EN
  logic [WIDTH-1:0] a_d, a_q;
  logic [WIDTH-1:0] b_d, b_q;
  logic             cin_d, cin_q;

  always_comb begin
    a_d   = A_in;
    b_d   = B_in;
    cin_d = Cin;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q   <= '0;
      b_q   <= '0;
      cin_q <= 1'b0;
    end else begin
      a_q   <= a_d;
      b_q   <= b_d;
      cin_q <= cin_d;
    end
  end

  assign op_a   = a_q;
  assign op_b   = b_q;
  assign op_cin = cin_q;
`else
  assign op_a   = A_in;
  assign op_b   = B_in;
  assign op_cin = Cin;
`endif

  logic [NG:0]      c_grp;
  logic [NG-1:0]    grp_g;
  logic [NG-1:0]    grp_p;
  logic [WIDTH-1:0] sum_w;

  assign c_grp[0] = op_cin;

  // Second level: group carries chain from each group's G/P.
  for (genvar k = 0; k < NG; k++) begin : g_grp
    cla_block4 u_blk (
      .a     (op_a[k*CLA_GROUP +: CLA_GROUP]),
      .b     (op_b[k*CLA_GROUP +: CLA_GROUP]),
      .cin   (c_grp[k]),
      .sum   (sum_w[k*CLA_GROUP +: CLA_GROUP]),
      .grp_g (grp_g[k]),
      .grp_p (grp_p[k])
    );
    assign c_grp[k+1] = grp_g[k] | (grp_p[k] & c_grp[k]);
  end

  logic [WIDTH-1:0] s_d, s_q;
  logic             cout_d, cout_q;

  always_comb begin
    s_d    = sum_w;
    cout_d = c_grp[NG];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_q    <= '0;
      cout_q <= 1'b0;
    end else begin
      s_q    <= s_d;
      cout_q <= cout_d;
    end
  end

  assign S    = s_q;
  assign Cout = cout_q;

endmodule

// File: tb/tb_cla_adder.sv
// tb/tb_cla_adder.sv - scoreboard bench for cla_adder (WIDTH 4 and 8)
// Honours CLA_INPUT_REG_EN for the expected latency.
module tb_cla_adder;

  localparam int W = 4;
`ifdef CLA_INPUT_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] a_in, b_in, s;
  logic         cin, cout;
  logic [7:0]   a8, b8, s8;
  logic         cin8, cout8;

  int n_cmp = 0;
  int n_bad = 0;

  logic [W:0] exp_q[$];
  bit         val_q[$];
  string      tag_q[$];
  logic [W:0] last_exp;

  always #5 clk = ~clk;

  cla_adder #(.WIDTH(W)) dut (
    .clk  (clk),
    .rst  (rst),
    .A_in (a_in),
    .B_in (b_in),
    .Cin  (cin),
    .S    (s),
    .Cout (cout)
  );

  cla_adder #(.WIDTH(8)) dut8 (
    .clk  (clk),
    .rst  (rst),
    .A_in (a8),
    .B_in (b8),
    .Cin  (cin8),
    .S    (s8),
    .Cout (cout8)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Drive one operand set; the queue holds exactly LAT entries in flight.
  task automatic run_cycle(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                           input bit v, input string tag);
    logic [W:0] e;
    bit         vv;
    string      t;
    @(negedge clk);
    a_in = a;
    b_in = b;
    cin  = c;
    exp_q.push_back({1'b0, a} + {1'b0, b} + (W+1)'(c));
    val_q.push_back(v);
    tag_q.push_back(tag);
    @(posedge clk);
    #1;
    if (exp_q.size() == LAT) begin
      e  = exp_q.pop_front();
      vv = val_q.pop_front();
      t  = tag_q.pop_front();
      last_exp = e;
      if (vv) check_eq(t, 32'({cout, s}), 32'(e));
    end
  endtask

  task automatic flush();
    repeat (LAT) run_cycle('0, '0, 1'b0, 1'b0, "flush");
  endtask

  task automatic check8(input logic [7:0] a, input logic [7:0] b, input logic c, input string tag);
    logic [8:0] e;
    @(negedge clk);
    a8   = a;
    b8   = b;
    cin8 = c;
    e    = {1'b0, a} + {1'b0, b} + 9'(c);
    repeat (LAT) @(posedge clk);
    #1;
    check_eq(tag, 32'({cout8, s8}), 32'(e));
  endtask

  initial begin
    int mult;
    int off;
    int idx;

    rst  = 1'b1;
    a_in = '1;
    b_in = '1;
    cin  = 1'b1;
    a8   = '0;
    b8   = '0;
    cin8 = 1'b0;
    #1;
    check_eq("reset_s", 32'(s), 32'd0);
    check_eq("reset_cout", 32'(cout), 32'd0);

    @(negedge clk);
    rst = 1'b0;
    run_cycle('1, '1, 1'b1, 1'b1, "pre_reset");
    repeat (LAT-1) run_cycle('0, '0, 1'b0, 1'b0, "flush");

    // Asynchronous clear between edges, then held through a clock edge.
    #2;
    rst = 1'b1;
    #1;
    check_eq("async_reset", 32'({cout, s}), 32'd0);
    exp_q.delete();
    val_q.delete();
    tag_q.delete();
    @(posedge clk);
    #1;
    check_eq("reset_held", 32'({cout, s}), 32'd0);
    #2;
    rst = 1'b0;

    for (int i = 0; i < 16; i++) run_cycle(W'(i), W'(i), 1'b0, 1'b1, "sweep_cin0");
    for (int i = 0; i < 16; i++) run_cycle(W'(i), W'(i), 1'b1, 1'b1, "sweep_cin1");

    // Inputs moved between edges must not reach the registered outputs.
    #2;
    a_in = 4'b1010;
    b_in = 4'b0110;
    cin  = 1'b1;
    #2;
    check_eq("hold_between_edges", 32'({cout, s}), 32'(last_exp));

    run_cycle('1, '0, 1'b1, 1'b1, "full_carry");
    run_cycle(4'b0001, '1, 1'b0, 1'b1, "carry_from_lsb");
    flush();

    // Reset while 0111+0111 is in flight; the first post-release result is 0011+0011.
    @(negedge clk);
    a_in = 4'b0111;
    b_in = 4'b0111;
    cin  = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    check_eq("midstream_reset", 32'({cout, s}), 32'd0);
    exp_q.delete();
    val_q.delete();
    tag_q.delete();
    @(posedge clk);
    #1;
    check_eq("midstream_reset_edge", 32'({cout, s}), 32'd0);
    #2;
    rst = 1'b0;
    run_cycle(4'b0011, 4'b0011, 1'b0, 1'b1, "post_reset");
    flush();

    // All 512 operand combinations in a shuffled order (odd stride is a permutation).
    mult = 181;
    off  = int'($urandom_range(0, 511));
    for (int k = 0; k < 512; k++) begin
      logic [8:0] v;
      idx = (k * mult + off) % 512;
      v   = 9'(idx);
      run_cycle(v[3:0], v[7:4], v[8], 1'b1, "exhaustive");
    end
    flush();

    check8(8'hFF, 8'h00, 1'b1, "w8_full_carry");
    check8(8'h0F, 8'h01, 1'b0, "w8_group_cross");
    check8(8'h80, 8'h80, 1'b0, "w8_top_carry");
    check8(8'hFF, 8'hFF, 1'b1, "w8_all_ones");
    for (int k = 0; k < 8; k++) begin
      check8(8'($urandom), 8'($urandom), 1'($urandom), "w8_random");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
